// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector (Mealy) with overlap mode,
// valid-qualified input and a saturating match counter.
module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = $clog2(MAX_LEN) + 1,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1001),
    parameter int                 DEF_LEN     = 4,
    parameter bit                 DEF_OVERLAP = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    input  logic               match_cnt_clr
);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   len_m1;
    logic               hit;
    logic               match_raw;

    // Window is the candidate pattern ending with the current sample;
    // mask keeps only the low len_q bits so unused pattern bits are ignored.
    always_comb begin
        window = {hist_q, in};
        len_m1 = len_q - LEN_W'(1);
        mask   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
        hit       = (((window ^ pat_q) & mask) == '0);
        match_raw = in_valid && !cfg_load && (fill_q >= len_m1) && hit;
    end

    assign match     = match_raw && rst;
    assign match_cnt = cnt_q;

    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (cfg_load) begin
            pat_d = cfg_pattern;
            ovl_d = cfg_overlap;
            if (cfg_len == '0)
                len_d = LEN_W'(1);
            else if (cfg_len > LEN_W'(MAX_LEN))
                len_d = LEN_W'(MAX_LEN);
            else
                len_d = cfg_len;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = window[MAX_LEN-2:0];
            // fill_q is the state: number of usable history bits held
            if (match_raw && !ovl_q)
                fill_d = '0;
            else if (fill_q >= len_m1)
                fill_d = len_m1;
            else
                fill_d = fill_q + LEN_W'(1);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (match_cnt_clr)
            cnt_d = match_raw ? CNT_W'(1) : '0;
        else if (match_raw && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q  <= DEF_PATTERN;
            len_q  <= LEN_W'(DEF_LEN);
            ovl_q  <= DEF_OVERLAP;
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: stimulus queues expected match/count
// per cycle, negedge monitors compare against the two DUT instances.
module tb_seq_detector_param;
    localparam int LW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          ld0, ov0, v0, b0, clr0, m0;
    logic [7:0]    pat0;
    logic [LW-1:0] len0;
    logic [7:0]    cnt0;
    logic          ld1, ov1, v1, b1, clr1, m1;
    logic [7:0]    pat1;
    logic [LW-1:0] len1;
    logic [2:0]    cnt1;

    seq_detector_param u0 (
        .clk(clk), .rst(rst), .cfg_load(ld0), .cfg_pattern(pat0), .cfg_len(len0),
        .cfg_overlap(ov0), .in_valid(v0), .in(b0), .match(m0), .match_cnt(cnt0),
        .match_cnt_clr(clr0)
    );

    seq_detector_param #(.CNT_W(3)) u1 (
        .clk(clk), .rst(rst), .cfg_load(ld1), .cfg_pattern(pat1), .cfg_len(len1),
        .cfg_overlap(ov1), .in_valid(v1), .in(b1), .match(m1), .match_cnt(cnt1),
        .match_cnt_clr(clr1)
    );

    typedef struct { bit m; int cnt; } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int n_chk = 0;
    int n_fail = 0;
    int ec0 = 0;
    int ec1 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            chk("u0_match", 32'(m0), 32'(e0.m));
            chk("u0_cnt", 32'(cnt0), e0.cnt);
        end
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            chk("u1_match", 32'(m1), 32'(e1.m));
            chk("u1_cnt", 32'(cnt1), e1.cnt);
        end
    end

    task automatic step0(input logic ld, input logic v, input logic b, input bit m);
        @(posedge clk);
        #1;
        ld0 = ld; v0 = v; b0 = b;
        q0.push_back('{m, ec0});
        if (m && ec0 < 255) ec0++;
    endtask

    task automatic step1(input logic ld, input logic v, input logic b, input logic clr, input bit m);
        @(posedge clk);
        #1;
        ld1 = ld; v1 = v; b1 = b; clr1 = clr;
        q1.push_back('{m, ec1});
        if (clr) ec1 = m ? 1 : 0;
        else if (m && ec1 < 7) ec1++;
    endtask

    // bits[n-1] is sent first
    task automatic run0(input int n, input logic [15:0] bits, input logic [15:0] exp);
        for (int i = n - 1; i >= 0; i--) step0(1'b0, 1'b1, bits[i], exp[i]);
    endtask

    // Load presents a would-be sample (valid=1,in=1) that must be discarded.
    task automatic cfg0(input logic [7:0] p, input logic [LW-1:0] l, input logic o);
        pat0 = p; len0 = l; ov0 = o;
        step0(1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic idle_chk0(input string name, input int exp_cnt);
        step0(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk(name, 32'(cnt0), exp_cnt);
    endtask

    task automatic idle_chk1(input string name, input int exp_cnt);
        step1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk(name, 32'(cnt1), exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        {ld0, ov0, v0, b0, clr0} = '0; pat0 = '0; len0 = '0;
        {ld1, ov1, v1, b1, clr1} = '0; pat1 = '0; len1 = '0;
        #1;
        chk("rst_match0", 32'(m0), 0);
        chk("rst_cnt0", 32'(cnt0), 0);
        chk("rst_cnt1", 32'(cnt1), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // 1: default 1001, non-overlap
        run0(7, 16'b1001001, 16'b0001000);
        idle_chk0("t1_cnt", 1);

        // 2: overlapping
        cfg0(8'h09, 4'd4, 1'b1);
        run0(7, 16'b1001001, 16'b0001001);
        idle_chk0("t2_cnt", 3);

        // 3: gap holds state; in=1 during gap must not match
        cfg0(8'h09, 4'd4, 1'b0);
        run0(3, 16'b100, 16'b000);
        repeat (3) step0(1'b0, 1'b0, 1'b1, 1'b0);
        run0(1, 16'b1, 16'b1);
        run0(3, 16'b100, 16'b000);
        cfg0(8'h09, 4'd4, 1'b0);
        run0(4, 16'b1001, 16'b0001);
        idle_chk0("t3_cnt", 5);

        // 4: len 8, clamp 12->8, clamp 0->1, len 1
        cfg0(8'b1011_0110, 4'd8, 1'b0);
        run0(8, 16'b1011_0110, 16'b0000_0001);
        cfg0(8'b1011_0110, 4'd12, 1'b0);
        run0(10, 16'b11_1011_0110, 16'b00_0000_0001);
        cfg0(8'h01, 4'd0, 1'b0);
        run0(2, 16'b10, 16'b10);
        cfg0(8'b0101_0101, 4'd1, 1'b0);
        run0(4, 16'b1101, 16'b1101);
        idle_chk0("t4_cnt", 11);

        // 5: 3-bit counter saturation and clear
        pat1 = 8'h01; len1 = 4'd1; ov1 = 1'b1;
        step1(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) step1(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        idle_chk1("t5_sat", 7);
        step1(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        idle_chk1("t5_clr_match", 1);
        step1(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle_chk1("t5_clr", 0);

        // 6: async reset mid-stream restores default config
        run0(3, 16'b100, 16'b100);
        @(negedge clk);
        #1;
        rst = 1'b0;
        v0 = 1'b0; v1 = 1'b0;
        ec0 = 0; ec1 = 0;
        #1;
        chk("t6_rst_match", 32'(m0), 0);
        chk("t6_rst_cnt0", 32'(cnt0), 0);
        chk("t6_rst_cnt1", 32'(cnt1), 0);
        @(negedge clk);
        rst = 1'b1;
        run0(4, 16'b1001, 16'b0001);
        idle_chk0("t6_cnt", 1);

        for (int i = 0; i < 50 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clk);
        if (q0.size() > 0 || q1.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q0.size() + q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
